// File: rtl/vec_isa_pkg.sv
// Vector ISA definitions shared by the issue stage and the vector ALU:
// opcodes, func and width codes, field positions, the canonical NOP and
// the issue-stage state encoding. Bit 0 is the MSB of every bus.
package vec_isa_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int INSTR_W  = 32;
  localparam int REG_AW   = 5;
  localparam int IMM_W    = 16;

  // Field positions inside an instruction word
  localparam int OPC_MSB  = 0;
  localparam int OPC_LSB  = 5;
  localparam int RD_MSB   = 6;
  localparam int RD_LSB   = 10;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 15;
  localparam int RB_MSB   = 16;
  localparam int RB_LSB   = 20;
  localparam int PPP_MSB  = 21;
  localparam int PPP_LSB  = 23;
  localparam int WW_MSB   = 24;
  localparam int WW_LSB   = 25;
  localparam int FUNC_MSB = 26;
  localparam int FUNC_LSB = 31;
  localparam int IMM_MSB  = 16;
  localparam int IMM_LSB  = 31;

  // Opcodes
  localparam logic [0:5] OP_R_ALU = 6'b101010;
  localparam logic [0:5] OP_LOAD  = 6'b100000;
  localparam logic [0:5] OP_STORE = 6'b100001;
  localparam logic [0:5] OP_BEZ   = 6'b100010;
  localparam logic [0:5] OP_BNEZ  = 6'b100011;
  localparam logic [0:5] OP_NOP   = 6'b111100;

  // R_ALU func codes
  localparam logic [0:5] VNOP  = 6'b000000;
  localparam logic [0:5] VAND  = 6'b000001;
  localparam logic [0:5] VOR   = 6'b000010;
  localparam logic [0:5] VXOR  = 6'b000011;
  localparam logic [0:5] VNOT  = 6'b000100;
  localparam logic [0:5] VMOV  = 6'b000101;
  localparam logic [0:5] VADD  = 6'b000110;
  localparam logic [0:5] VSUB  = 6'b000111;
  localparam logic [0:5] VMUL  = 6'b001000;
  localparam logic [0:5] VDIV  = 6'b001001;
  localparam logic [0:5] VMOD  = 6'b001010;
  localparam logic [0:5] VSQ   = 6'b001011;
  localparam logic [0:5] VSQRT = 6'b001100;

  // Element width codes (WW field)
  localparam logic [0:1] Width_8  = 2'b00;
  localparam logic [0:1] Width_16 = 2'b01;
  localparam logic [0:1] Width_32 = 2'b10;
  localparam logic [0:1] Width_64 = 2'b11;

  localparam logic [0:INSTR_W-1] NOP_INSTR = {OP_NOP, 26'b0};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_HOLD      = 2'd2
  } issue_state_t;

  function automatic logic [0:5] opcode_of(input logic [0:INSTR_W-1] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [0:REG_AW-1] rd_of(input logic [0:INSTR_W-1] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/vec_issue_stage_if.sv
// IF/ID, writeback and ID/EX signals of the vector issue stage.
// Handshake: IF presents IF_ID_Instr with IF_ID_valid=1 and holds it while
// stall=1; the instruction counts as consumed on any clock edge where
// stall=0. ID_EX_* is presented to the ALU with ID_EX_valid and is frozen
// while ex_busy=1. br_taken is a one-cycle pulse; IF redirects to
// br_target and the IF_ID word present during that pulse is dropped.
interface vec_issue_stage_if;
  import vec_isa_pkg::*;

  logic [0:INSTR_W-1] IF_ID_Instr;
  logic               IF_ID_valid;
  logic               ex_busy;
  logic               WB_wr_en;
  logic [0:REG_AW-1]  WB_rD;
  logic [0:DATA_W-1]  WB_data;
  logic [0:INSTR_W-1] ID_EX_Instr;
  logic [0:DATA_W-1]  ID_EX_A;
  logic [0:DATA_W-1]  ID_EX_B;
  logic               ID_EX_valid;
  logic               stall;
  logic               br_taken;
  logic [0:IMM_W-1]   br_target;

  // Issue stage side
  modport slave (
    input  IF_ID_Instr, IF_ID_valid, ex_busy, WB_wr_en, WB_rD, WB_data,
    output ID_EX_Instr, ID_EX_A, ID_EX_B, ID_EX_valid, stall, br_taken, br_target
  );

  // Fetch / ALU / writeback side
  modport master (
    output IF_ID_Instr, IF_ID_valid, ex_busy, WB_wr_en, WB_rD, WB_data,
    input  ID_EX_Instr, ID_EX_A, ID_EX_B, ID_EX_valid, stall, br_taken, br_target
  );
endinterface

// File: rtl/vec_regfile.sv
// 32x64 vector register file: three combinational read ports (rA, rB, rD),
// one write port, R0 hardwired to zero, write-through bypass on reads.
module vec_regfile
  import vec_isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [0:REG_AW-1] ra_addr,
  input  logic [0:REG_AW-1] rb_addr,
  input  logic [0:REG_AW-1] rd_addr,
  output logic [0:DATA_W-1] ra_data,
  output logic [0:DATA_W-1] rb_data,
  output logic [0:DATA_W-1] rd_data,
  input  logic              wr_en,
  input  logic [0:REG_AW-1] wr_addr,
  input  logic [0:DATA_W-1] wr_data
);

  logic [0:DATA_W-1] regs [NUM_REGS];

  // Storage update; R0 is never written so it stays at its reset value of 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write landing this cycle is visible to readers in the same cycle
  assign ra_data = (ra_addr == '0) ? '0 :
                   (wr_en && (wr_addr == ra_addr)) ? wr_data : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 :
                   (wr_en && (wr_addr == rb_addr)) ? wr_data : regs[rb_addr];
  assign rd_data = (rd_addr == '0) ? '0 :
                   (wr_en && (wr_addr == rd_addr)) ? wr_data : regs[rd_addr];

endmodule

// File: rtl/vec_issue_stage.sv
// Vector decode/issue stage: decodes IF/ID, reads operands, resolves
// BEZ/BNEZ, inserts a bubble on load-use and freezes ID/EX while the ALU
// is busy with a multi-cycle op.
module vec_issue_stage
  import vec_isa_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vec_issue_stage_if.slave      bus,
  output issue_state_t          state_dbg
);

  issue_state_t      state;
  logic [0:5]        cur_op;
  logic [0:REG_AW-1] cur_rd, cur_ra, cur_rb;
  logic [0:IMM_W-1]  cur_imm;
  logic [0:DATA_W-1] ra_data, rb_data, rd_data;
  logic [0:INSTR_W-1] dec_instr;
  logic [0:DATA_W-1] dec_a, dec_b;
  logic              dec_valid, dec_taken;
  logic [0:REG_AW-1] ex_rd;
  logic              uses_rd, hazard;

  assign cur_op  = bus.IF_ID_Instr[OPC_MSB:OPC_LSB];
  assign cur_rd  = bus.IF_ID_Instr[RD_MSB:RD_LSB];
  assign cur_ra  = bus.IF_ID_Instr[RA_MSB:RA_LSB];
  assign cur_rb  = bus.IF_ID_Instr[RB_MSB:RB_LSB];
  assign cur_imm = bus.IF_ID_Instr[IMM_MSB:IMM_LSB];
  assign state_dbg = state;

  vec_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (cur_ra),
    .rb_addr (cur_rb),
    .rd_addr (cur_rd),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_data (rd_data),
    .wr_en   (bus.WB_wr_en),
    .wr_addr (bus.WB_rD),
    .wr_data (bus.WB_data)
  );

  // Load-use: a LOAD sitting in ID/EX whose destination the IF/ID word reads
  assign ex_rd   = rd_of(bus.ID_EX_Instr);
  assign uses_rd = (cur_op == OP_STORE) || (cur_op == OP_BEZ) || (cur_op == OP_BNEZ);
  assign hazard  = bus.IF_ID_valid && bus.ID_EX_valid &&
                   (opcode_of(bus.ID_EX_Instr) == OP_LOAD) && (ex_rd != '0) &&
                   ((ex_rd == cur_ra) || (ex_rd == cur_rb) || (uses_rd && (ex_rd == cur_rd)));

  // During the br_taken pulse the IF/ID word is dropped, so it never stalls
  assign bus.stall = !bus.br_taken && (bus.ex_busy || hazard);

  // Decode: operand selection and branch resolution for the IF/ID word
  always_comb begin
    dec_instr = bus.IF_ID_Instr;
    dec_a     = ra_data;
    dec_b     = rb_data;
    dec_valid = 1'b1;
    dec_taken = 1'b0;
    case (cur_op)
      OP_R_ALU: ;
      OP_LOAD: begin
        dec_a = {{(DATA_W-IMM_W){1'b0}}, cur_imm};
      end
      OP_STORE: begin
        dec_a = {{(DATA_W-IMM_W){1'b0}}, cur_imm};
        dec_b = rd_data;
      end
      OP_BEZ, OP_BNEZ: begin
        dec_b     = rd_data;
        dec_taken = (cur_op == OP_BEZ) ? (rd_data == '0) : (rd_data != '0);
        if (dec_taken) begin
          dec_instr = NOP_INSTR;
          dec_a     = '0;
          dec_b     = '0;
          dec_valid = 1'b0;
        end
      end
      default: begin
        dec_instr = NOP_INSTR;
        dec_a     = '0;
        dec_b     = '0;
        dec_valid = 1'b0;
      end
    endcase
  end

  // Issue FSM with registered ID/EX and branch outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_RUN;
      bus.ID_EX_Instr <= NOP_INSTR;
      bus.ID_EX_A     <= '0;
      bus.ID_EX_B     <= '0;
      bus.ID_EX_valid <= 1'b0;
      bus.br_taken    <= 1'b0;
      bus.br_target   <= '0;
    end else begin
      bus.br_taken <= 1'b0;
      if (bus.ex_busy) begin
        state <= ST_HOLD;
      end else if (bus.br_taken || hazard || !bus.IF_ID_valid) begin
        state           <= (hazard && !bus.br_taken) ? ST_LU_BUBBLE : ST_RUN;
        bus.ID_EX_Instr <= NOP_INSTR;
        bus.ID_EX_A     <= '0;
        bus.ID_EX_B     <= '0;
        bus.ID_EX_valid <= 1'b0;
      end else begin
        state           <= ST_RUN;
        bus.ID_EX_Instr <= dec_instr;
        bus.ID_EX_A     <= dec_a;
        bus.ID_EX_B     <= dec_b;
        bus.ID_EX_valid <= dec_valid;
        if (dec_taken) begin
          bus.br_taken  <= 1'b1;
          bus.br_target <= cur_imm;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_stage.sv
// Bench for vec_issue_stage: expected ID/EX words are pushed when an
// instruction is driven and popped one cycle later when the stage issues.
module tb_vec_issue_stage;
  import vec_isa_pkg::*;

  localparam int SB_W = 1 + INSTR_W + 2 * DATA_W;

  logic clk = 1'b0;
  logic reset;
  issue_state_t state_dbg;
  vec_issue_stage_if bus();

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [0:DATA_W-1] model_rf [NUM_REGS];

  vec_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [0:31] mk_r(input logic [0:5] func, input logic [0:4] rd,
                                       input logic [0:4] ra, input logic [0:4] rb,
                                       input logic [0:2] ppp, input logic [0:1] ww);
    return {OP_R_ALU, rd, ra, rb, ppp, ww, func};
  endfunction

  function automatic logic [0:31] mk_i(input logic [0:5] op, input logic [0:4] rd,
                                       input logic [0:4] ra, input logic [0:15] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [SB_W-1:0] pack(input logic v, input logic [0:31] ins,
                                           input logic [0:63] a, input logic [0:63] b);
    return {v, ins, a, b};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.IF_ID_Instr = NOP_INSTR;
    bus.IF_ID_valid = 1'b0;
    bus.ex_busy     = 1'b0;
    bus.WB_wr_en    = 1'b0;
    bus.WB_rD       = '0;
    bus.WB_data     = '0;
  endtask

  task automatic wb_write(input logic [0:4] rd, input logic [0:63] data);
    bus.WB_wr_en = 1'b1;
    bus.WB_rD    = rd;
    bus.WB_data  = data;
    if (rd != 5'd0) model_rf[rd] = data;
  endtask

  task automatic issue(input logic [0:31] ins);
    bus.IF_ID_Instr = ins;
    bus.IF_ID_valid = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model_rf[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    checks++; if (bus.ID_EX_Instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr: got %h expected %h", bus.ID_EX_Instr, NOP_INSTR); end
    checks++; if (bus.ID_EX_A !== 64'd0) begin errors++; $display("FAIL reset_a: got %h expected 0", bus.ID_EX_A); end
    checks++; if (bus.ID_EX_B !== 64'd0) begin errors++; $display("FAIL reset_b: got %h expected 0", bus.ID_EX_B); end
    checks++; if (bus.ID_EX_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ID_EX_valid); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %b expected 0", bus.br_taken); end
    checks++; if (bus.br_target !== 16'd0) begin errors++; $display("FAIL reset_br_target: got %h expected 0", bus.br_target); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_RUN); end
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_alu_issue();
    logic [SB_W-1:0] got, exp;
    logic [0:31] ins;
    logic [0:4] ra, rb;
    wb_write(5'd1, 64'h0102030405060708); tick();
    wb_write(5'd2, 64'h1111111111111111); tick();
    for (int r = 3; r < 12; r++) begin
      wb_write(r[4:0], {$urandom, $urandom}); tick();
    end
    bus.WB_wr_en = 1'b0;
    ins = mk_r(VADD, 5'd3, 5'd1, 5'd2, 3'b000, Width_8);
    issue(ins);
    exp_q.push_back(pack(1'b1, ins, model_rf[1], model_rf[2]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL alu_vadd: got %h expected %h", got, exp); end
    // Back-to-back random R_ALU ops; WW/PPP must pass through untouched
    for (int i = 0; i < 6; i++) begin
      ra = 5'($urandom_range(0, 11));
      rb = 5'($urandom_range(0, 11));
      ins = mk_r(6'($urandom_range(0, 12)), 5'($urandom_range(12, 31)), ra, rb,
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      issue(ins);
      exp_q.push_back(pack(1'b1, ins, model_rf[ra], model_rf[rb]));
      tick();
      got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL alu_random: got %h expected %h", got, exp); end
    end
    // STORE: A = zero-extended imm, B = rD data
    ins = mk_i(OP_STORE, 5'd1, 5'd0, 16'h0008);
    issue(ins);
    exp_q.push_back(pack(1'b1, ins, 64'h8, model_rf[1]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL store_issue: got %h expected %h", got, exp); end
    // No valid instruction: NOP bubble
    bus.IF_ID_valid = 1'b0;
    exp_q.push_back(pack(1'b0, NOP_INSTR, 64'd0, 64'd0));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL idle_nop: got %h expected %h", got, exp); end
  endtask

  task automatic test_bypass();
    logic [SB_W-1:0] got, exp;
    logic [0:31] ins;
    wb_write(5'd5, 64'hDEAD);
    ins = mk_r(VADD, 5'd6, 5'd5, 5'd2, 3'b000, Width_64);
    issue(ins);
    exp_q.push_back(pack(1'b1, ins, 64'hDEAD, model_rf[2]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL bypass_r5: got %h expected %h", got, exp); end
    wb_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    ins = mk_r(VOR, 5'd6, 5'd0, 5'd0, 3'b000, Width_64);
    issue(ins);
    exp_q.push_back(pack(1'b1, ins, 64'd0, 64'd0));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL r0_same_cycle: got %h expected %h", got, exp); end
    bus.WB_wr_en = 1'b0;
    exp_q.push_back(pack(1'b1, ins, 64'd0, 64'd0));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL r0_after_write: got %h expected %h", got, exp); end
    bus.IF_ID_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    logic [SB_W-1:0] got, exp;
    logic [0:31] ld, vand;
    wb_write(5'd4, 64'h4444_0000_0000_4444); tick();
    bus.WB_wr_en = 1'b0;
    ld = mk_i(OP_LOAD, 5'd4, 5'd0, 16'h1234);
    issue(ld);
    exp_q.push_back(pack(1'b1, ld, 64'h1234, model_rf[ld[16:20]]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL load_issue: got %h expected %h", got, exp); end
    vand = mk_r(VAND, 5'd8, 5'd4, 5'd1, 3'b000, Width_16);
    issue(vand);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", bus.stall); end
    exp_q.push_back(pack(1'b0, NOP_INSTR, 64'd0, 64'd0));
    exp_q.push_back(pack(1'b1, vand, model_rf[4], model_rf[1]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL lu_bubble: got %h expected %h", got, exp); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.stall); end
    checks++; if (state_dbg !== ST_LU_BUBBLE) begin errors++; $display("FAIL lu_state: got %0d expected %0d", state_dbg, ST_LU_BUBBLE); end
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL lu_vand: got %h expected %h", got, exp); end
    bus.IF_ID_valid = 1'b0;
    tick();
  endtask

  task automatic test_ex_busy();
    logic [SB_W-1:0] got, exp, exp_div;
    logic [0:31] vdiv, vadd;
    vdiv = mk_r(VDIV, 5'd9, 5'd1, 5'd2, 3'b101, Width_32);
    issue(vdiv);
    exp_div = pack(1'b1, vdiv, model_rf[1], model_rf[2]);
    exp_q.push_back(exp_div);
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL div_issue: got %h expected %h", got, exp); end
    bus.ex_busy = 1'b1;
    vadd = mk_r(VADD, 5'd10, 5'd2, 5'd1, 3'b000, Width_64);
    issue(vadd);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL busy_stall: cycle %0d got %b expected 1", k, bus.stall); end
      exp_q.push_back(exp_div);
      tick();
      got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
      checks++; if (got !== exp) begin errors++; $display("FAIL busy_hold: cycle %0d got %h expected %h", k, got, exp); end
    end
    checks++; if (state_dbg !== ST_HOLD) begin errors++; $display("FAIL busy_state: got %0d expected %0d", state_dbg, ST_HOLD); end
    bus.ex_busy = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL busy_release: got %b expected 0", bus.stall); end
    exp_q.push_back(pack(1'b1, vadd, model_rf[2], model_rf[1]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL busy_next_issue: got %h expected %h", got, exp); end
    bus.IF_ID_valid = 1'b0;
    tick();
  endtask

  task automatic test_branch();
    logic [SB_W-1:0] got, exp;
    issue(mk_i(OP_BEZ, 5'd0, 5'd0, 16'h0040));
    exp_q.push_back(pack(1'b0, NOP_INSTR, 64'd0, 64'd0));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL bez_as_nop: got %h expected %h", got, exp); end
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL bez_taken: got %b expected 1", bus.br_taken); end
    checks++; if (bus.br_target !== 16'h0040) begin errors++; $display("FAIL bez_target: got %h expected 0040", bus.br_target); end
    // Word in IF/ID during the br_taken pulse is dropped
    issue(mk_r(VADD, 5'd11, 5'd1, 5'd2, 3'b000, Width_8));
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
    exp_q.push_back(pack(1'b0, NOP_INSTR, 64'd0, 64'd0));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL flush_drop: got %h expected %h", got, exp); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL br_pulse: got %b expected 0", bus.br_taken); end
    // BNEZ on a zero register is not taken
    issue(mk_i(OP_BNEZ, 5'd0, 5'd0, 16'h0080));
    tick();
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bnez_zero: got %b expected 0", bus.br_taken); end
    // BNEZ on a nonzero register is taken
    issue(mk_i(OP_BNEZ, 5'd1, 5'd0, 16'h00AA));
    tick();
    checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL bnez_taken: got %b expected 1", bus.br_taken); end
    checks++; if (bus.br_target !== 16'h00AA) begin errors++; $display("FAIL bnez_target: got %h expected 00aa", bus.br_target); end
    checks++; if (bus.ID_EX_valid !== 1'b0) begin errors++; $display("FAIL bnez_valid: got %b expected 0", bus.ID_EX_valid); end
    bus.IF_ID_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_bubble();
    logic [SB_W-1:0] got, exp;
    logic [0:31] ins;
    issue(mk_i(OP_LOAD, 5'd7, 5'd0, 16'h0000));
    tick();
    issue(mk_r(VAND, 5'd8, 5'd7, 5'd0, 3'b000, Width_8));
    tick();
    checks++; if (state_dbg !== ST_LU_BUBBLE) begin errors++; $display("FAIL rb_pre_state: got %0d expected %0d", state_dbg, ST_LU_BUBBLE); end
    reset = 1'b1;
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B};
    exp = pack(1'b0, NOP_INSTR, 64'd0, 64'd0);
    checks++; if (got !== exp) begin errors++; $display("FAIL rb_idex: got %h expected %h", got, exp); end
    checks++; if (state_dbg !== ST_RUN) begin errors++; $display("FAIL rb_state: got %0d expected %0d", state_dbg, ST_RUN); end
    checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL rb_br_taken: got %b expected 0", bus.br_taken); end
    reset = 1'b0;
    clear_model();
    drive_idle();
    // Register file contents were cleared by reset
    ins = mk_r(VADD, 5'd3, 5'd1, 5'd2, 3'b000, Width_8);
    issue(ins);
    exp_q.push_back(pack(1'b1, ins, model_rf[1], model_rf[2]));
    tick();
    got = {bus.ID_EX_valid, bus.ID_EX_Instr, bus.ID_EX_A, bus.ID_EX_B}; exp = exp_q.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rb_rf_cleared: got %h expected %h", got, exp); end
    bus.IF_ID_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_issue();
    test_bypass();
    test_load_use();
    test_ex_busy();
    test_branch();
    test_reset_in_bubble();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_issue_stage.md
Name: vec_issue_stage

Overview:
Instruction decode/issue stage feeding the vector ALU's ID/EX interface. Owns the 32x64 vector register file and decodes IF/ID instructions. Issues ID_EX_Instr / ID_EX_A / ID_EX_B with a valid flag, resolves BEZ/BNEZ, detects load-use hazards and honours ALU back-pressure from multi-cycle ops (VDIV/VMOD/VSQRT).

Parameters:
NUM_REGS, 32, register file depth; R0 reads as 0.
DATA_W, 64, vector register width.
INSTR_W, 32, instruction width; bit 0 = MSB, as on the ALU side.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
IF_ID_Instr  in  [0:31]  fetched instruction.
IF_ID_valid  in  1  IF_ID_Instr holds a real instruction.
ex_busy  in  1  ALU is still computing a multi-cycle op; hold ID/EX.
WB_wr_en  in  1  register file write enable.
WB_rD  in  [0:4]  write address.
WB_data  in  [0:63]  write data.
ID_EX_Instr  out  [0:31]  instruction to the ALU.
ID_EX_A  out  [0:63]  rA operand; for LOAD/STORE, holds zero-extended imm[16:31].
ID_EX_B  out  [0:63]  rB operand; for STORE, holds rD data.
ID_EX_valid  out  1  ID/EX register holds an issuable op.
stall  out  1  combinational; IF must hold IF_ID_Instr this cycle.
br_taken  out  1  registered, one-cycle pulse; IF must redirect and flush.
br_target  out  [0:15]  registered branch target word address.

Behaviour:
- Field map: [0:5] opcode, [6:10] rD, [11:15] rA, [16:20] rB, [21:23] PPP, [24:25] WW, [26:31] func, [16:31] imm.
- Opcodes: R_ALU 101010, LOAD 100000, STORE 100001, BEZ 100010, BNEZ 100011, NOP 111100. Any other opcode is issued as a NOP.
- Register file writes on the clk edge when WB_wr_en=1 and WB_rD!=0. Writes to R0 are ignored.
- Register file reads are combinational, with a write-through bypass: if WB_wr_en=1 and WB_rD equals the read address (nonzero), the read returns WB_data in the same cycle.
- Reset: all registers clear to 0. ID_EX_Instr = NOP encoding {111100, 26'b0}. ID_EX_A, ID_EX_B, ID_EX_valid, br_taken and br_target are 0. FSM goes to RUN.
- Latency: an instruction accepted in cycle N appears on ID_EX_* in cycle N+1.
- FSM states:
  - RUN:
    - ex_busy=1 → HOLD. ID/EX keeps its value; stall=1.
    - Load-use hazard → LU_BUBBLE. A hazard exists when ID_EX_valid=1, ID_EX opcode is LOAD, ID_EX rD != 0, and rD matches the current rA or rB (or rD for STORE/branch). On entry, ID/EX loads the NOP encoding with valid=0, and stall=1.
    - Otherwise, accept the instruction if IF_ID_valid=1; with IF_ID_valid=0, ID/EX loads NOP with valid=0.
  - LU_BUBBLE: stall=0. Accept the held instruction this cycle, then return to RUN.
  - HOLD: stall=1 while ex_busy=1. On ex_busy=0, behave as RUN in that same cycle.
- ex_busy takes priority over the hazard check when both are true.
- Branches:
  - BEZ is taken when the 64-bit rD value == 0; BNEZ is taken when it != 0.
  - When taken, br_taken=1 and br_target=imm in the next cycle, and the branch itself is issued as a NOP with valid=0.
  - The instruction in IF_ID during the br_taken cycle is discarded: not issued, and IF_ID_valid is ignored.
- WW and PPP pass through untouched; the ALU interprets them.
- Reset asserted mid-stall or mid-HOLD returns to the reset state in one cycle, with no partial issue.

Decomposition:
- Shared package vec_isa_pkg: opcode constants (R_ALU, LOAD, STORE, BEZ, BNEZ, NOP), func codes VAND..VSQRT, VNOP, width codes Width_8..Width_64, field-position constants, and the NOP encoding. The ALU imports the same package.
- One sub-module, vec_regfile: 32x64 storage, 2 read ports plus 1 rD read port, 1 write port, R0 hardwired to 0, write-through bypass.

Test Plan:
- Reset, then write R1=64'h0102030405060708 and R2=64'h1111... via WB; issue R_ALU VADD rD=3, rA=1, rB=2, WW=00 → next cycle ID_EX_A=0102...08, ID_EX_B=1111..., ID_EX_valid=1.
- Same-cycle WB write R5=64'hDEAD with a read of R5 → ID_EX_A=64'hDEAD, proving the bypass. Write to R0 followed by a read of R0 → 0.
- LOAD rD=4, then VAND rA=4 → stall=1 for one cycle, one bubble issued (NOP, valid=0), then VAND issued in the following cycle.
- ex_busy held high for 3 cycles after a VDIV → ID/EX unchanged and stall=1 for 3 cycles; the next instruction issues on the cycle ex_busy falls.
- BEZ rD=0 with imm=16'h0040 → br_taken=1, br_target=0040 for one cycle, and the following IF_ID instruction is dropped. BNEZ on a zero register → no branch taken.
- Reset asserted during LU_BUBBLE → next cycle all outputs at reset values, ID_EX_valid=0.
